// File: rtl/neural_layer_sequencer.sv
// rtl/neural_layer_sequencer.sv - sequences one shared 2x2 neural layer datapath across LAYERS layers
module neural_layer_sequencer #(
    parameter int WIDTH  = 16,
    parameter int LAYERS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cfg_we,
    input  logic [4:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic             cfg_err,
    output logic [WIDTH-1:0] nl_in1,
    output logic [WIDTH-1:0] nl_in2,
    output logic [WIDTH-1:0] nl_c11,
    output logic [WIDTH-1:0] nl_c12,
    output logic [WIDTH-1:0] nl_c21,
    output logic [WIDTH-1:0] nl_c22,
    input  logic [WIDTH-1:0] nl_out1,
    input  logic [WIDTH-1:0] nl_out2,
    output logic [2:0]       layer_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [2:0] LAST_LAYER = 3'(LAYERS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [2:0]       layer_q, layer_d;
    logic             cfg_err_q;
    logic [WIDTH-1:0] coeff_q [LAYERS][4];
    logic             cfg_ok;
    logic             cfg_bad;
    logic [2:0]       rd_layer;

    // Writes only land while idle and only into layers that exist; anything else is flagged.
    assign cfg_ok  = cfg_we && (state_q == ST_IDLE) && ({1'b0, cfg_addr[4:2]} < 4'(LAYERS));
    assign cfg_bad = cfg_we && !cfg_ok;

    // Next-state and handshake outputs of the layer sequencer.
    always_comb begin
        state_d   = state_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        layer_d   = layer_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x1_d    = in_a;
                    x2_d    = in_b;
                    layer_d = 3'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                x1_d = nl_out1;
                x2_d = nl_out2;
                if (layer_q == LAST_LAYER) begin
                    state_d = ST_DONE;
                end else begin
                    layer_d = layer_q + 3'd1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, working pair, layer counter and write-reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            x1_q      <= '0;
            x2_q      <= '0;
            layer_q   <= 3'd0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            layer_q   <= layer_d;
            cfg_err_q <= cfg_bad;
        end
    end

    // Per-layer coefficient store, written from the config port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LAYERS; l++) begin
                for (int i = 0; i < 4; i++) begin
                    coeff_q[l][i] <= '0;
                end
            end
        end else begin
            for (int l = 0; l < LAYERS; l++) begin
                for (int i = 0; i < 4; i++) begin
                    if (cfg_ok && cfg_addr[4:2] == 3'(l) && cfg_addr[1:0] == 2'(i)) begin
                        coeff_q[l][i] <= cfg_data;
                    end
                end
            end
        end
    end

    // Coefficient read mux: the active layer while running, layer 0 otherwise.
    always_comb begin
        rd_layer = (state_q == ST_RUN) ? layer_q : 3'd0;
        nl_c11   = coeff_q[0][0];
        nl_c12   = coeff_q[0][1];
        nl_c21   = coeff_q[0][2];
        nl_c22   = coeff_q[0][3];
        for (int l = 1; l < LAYERS; l++) begin
            if (rd_layer == 3'(l)) begin
                nl_c11 = coeff_q[l][0];
                nl_c12 = coeff_q[l][1];
                nl_c21 = coeff_q[l][2];
                nl_c22 = coeff_q[l][3];
            end
        end
    end

    assign nl_in1    = x1_q;
    assign nl_in2    = x2_q;
    assign out1      = x1_q;
    assign out2      = x2_q;
    assign layer_idx = layer_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_neural_layer_sequencer.sv
// tb/tb_neural_layer_sequencer.sv - self-checking bench for neural_layer_sequencer
module tb_neural_layer_sequencer;

    localparam int WIDTH  = 16;
    localparam int LAYERS = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_a, in_b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1, out2;
    logic             out_valid;
    logic             out_ready;
    logic             cfg_we;
    logic [4:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             cfg_err;
    logic [WIDTH-1:0] nl_in1, nl_in2, nl_c11, nl_c12, nl_c21, nl_c22;
    logic [WIDTH-1:0] nl_out1, nl_out2;
    logic [2:0]       layer_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_coeff [8][4];

    neural_layer_sequencer #(.WIDTH(WIDTH), .LAYERS(LAYERS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
        .out1(out1), .out2(out2), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .nl_in1(nl_in1), .nl_in2(nl_in2),
        .nl_c11(nl_c11), .nl_c12(nl_c12), .nl_c21(nl_c21), .nl_c22(nl_c22),
        .nl_out1(nl_out1), .nl_out2(nl_out2), .layer_idx(layer_idx)
    );

    // Stub layer: each output is its input plus the diagonal coefficient.
    assign nl_out1 = nl_in1 + nl_c11;
    assign nl_out2 = nl_in2 + nl_c22;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x1, x2;
        x1 = a;
        x2 = b;
        for (int l = 0; l < LAYERS; l++) begin
            x1 = x1 + m_coeff[l][0];
            x2 = x2 + m_coeff[l][3];
        end
        return {x1, x2};
    endfunction

    task automatic cfg_write(input logic [2:0] layer, input logic [1:0] idx, input logic [15:0] data);
        bit ok;
        ok = (int'(layer) < LAYERS);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = {layer, idx};
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check_eq("cfg_err", 32'(cfg_err), 32'(!ok));
        if (ok) m_coeff[layer][idx] = data;
        if (!ok) begin
            @(posedge clk); #1;
            check_eq("cfg_err_pulse", 32'(cfg_err), 32'd0);
        end
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int hold,
                             input bit cfg_in_run, input bit wr_same, input logic [15:0] wr_val);
        logic [15:0] x1, x2;
        int e;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        if (wr_same) begin
            cfg_we   = 1'b1;
            cfg_addr = 5'b00000;
            cfg_data = wr_val;
        end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (wr_same) m_coeff[0][0] = wr_val;
        x1 = a;
        x2 = b;
        e  = 0;
        while (!out_valid && e < 20) begin
            check_eq("run_in_ready", 32'(in_ready), 32'd0);
            if (e < LAYERS) begin
                check_eq("run_layer_idx", 32'(layer_idx), 32'(e));
                check_eq("run_nl_in", {nl_in1, nl_in2}, {x1, x2});
                check_eq("run_nl_c11_c22", {nl_c11, nl_c22}, {m_coeff[e][0], m_coeff[e][3]});
                check_eq("run_nl_c12_c21", {nl_c12, nl_c21}, {m_coeff[e][1], m_coeff[e][2]});
                x1 = x1 + m_coeff[e][0];
                x2 = x2 + m_coeff[e][3];
            end
            if (cfg_in_run && e == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 5'($urandom);
                cfg_data = 16'($urandom);
            end
            @(posedge clk); #1;
            if (cfg_we) begin
                check_eq("cfg_err_run", 32'(cfg_err), 32'd1);
                cfg_we = 1'b0;
            end
            e++;
        end
        check_eq("latency", 32'(e), 32'(LAYERS));
        check_eq("result", {out1, out2}, {x1, x2});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_data", {out1, out2}, {x1, x2});
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("post_valid", 32'(out_valid), 32'd0);
        check_eq("post_in_ready", 32'(in_ready), 32'd1);
        check_eq("post_keep", {out1, out2}, {x1, x2});
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] exp_v;
        logic [15:0] ra, rb;
        int last_acc;
        bit acc;

        for (int l = 0; l < 8; l++) for (int i = 0; i < 4; i++) m_coeff[l][i] = '0;
        rst_n = 1'b0; in_a = '0; in_b = '0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
        check_eq("rst_layer_idx", 32'(layer_idx), 32'd0);
        check_eq("rst_out", {out1, out2}, 32'd0);
        check_eq("rst_coeff", {nl_c11, nl_c22}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed two-layer example.
        cfg_write(3'd0, 2'd0, 16'd1);
        cfg_write(3'd0, 2'd3, 16'd2);
        cfg_write(3'd1, 2'd0, 16'd10);
        cfg_write(3'd1, 2'd3, 16'd20);
        send_pair(16'd5, 16'd7, 0, 1'b0, 1'b0, 16'd0);
        check_eq("t1_out", {out1, out2}, {16'd16, 16'd29});

        // Back-pressure in DONE.
        send_pair(16'($urandom), 16'($urandom), 10, 1'b0, 1'b0, 16'd0);

        // Rejected writes: while running and to a missing layer.
        send_pair(16'($urandom), 16'($urandom), 0, 1'b1, 1'b0, 16'd0);
        cfg_write(3'd2, 2'd0, 16'($urandom));
        cfg_write(3'd7, 2'd1, 16'($urandom));
        send_pair(16'($urandom), 16'($urandom), 2, 1'b0, 1'b0, 16'd0);

        // Write and accept in the same idle cycle.
        send_pair(16'($urandom), 16'($urandom), 0, 1'b0, 1'b1, 16'($urandom));

        // Random coefficients and pairs.
        repeat (3) begin
            for (int l = 0; l < LAYERS; l++)
                for (int i = 0; i < 4; i++)
                    cfg_write(3'(l), 2'(i), 16'($urandom));
            repeat (3) send_pair(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'd0);
        end

        // Wrap at layer 0 carried unchanged through layer 1.
        cfg_write(3'd0, 2'd0, 16'd1);
        cfg_write(3'd1, 2'd0, 16'd0);
        send_pair(16'hFFFF, 16'($urandom), 0, 1'b0, 1'b0, 16'd0);
        check_eq("t5_wrap", 32'(out1), 32'd0);

        // Asynchronous reset in the second running cycle.
        @(negedge clk);
        in_a = 16'($urandom); in_b = 16'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("t4_second_run", 32'(layer_idx), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t4_out_valid", 32'(out_valid), 32'd0);
        check_eq("t4_in_ready", 32'(in_ready), 32'd1);
        check_eq("t4_coeff_a", {nl_c11, nl_c22}, 32'd0);
        check_eq("t4_coeff_b", {nl_c12, nl_c21}, 32'd0);
        for (int l = 0; l < 8; l++) for (int i = 0; i < 4; i++) m_coeff[l][i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ra = 16'($urandom); rb = 16'($urandom);
        send_pair(ra, rb, 0, 1'b0, 1'b0, 16'd0);
        check_eq("t4_passthru", {out1, out2}, {ra, rb});

        // Back-to-back streaming.
        for (int l = 0; l < LAYERS; l++)
            for (int i = 0; i < 4; i++)
                cfg_write(3'(l), 2'(i), 16'($urandom));
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 16'($urandom); in_b = 16'($urandom);
        last_acc = -1;
        for (int c = 0; c < 70; c++) begin
            in_valid = (c < 50);
            if (out_valid) begin
                check_eq("b2b_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check_eq("b2b_result", {out1, out2}, exp_v);
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(in_a, in_b));
                if (last_acc >= 0) check_eq("b2b_interval", 32'(c - last_acc), 32'(LAYERS + 2));
                last_acc = c;
            end
            @(posedge clk); #1;
            if (acc) begin
                in_a = 16'($urandom);
                in_b = 16'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
